// File: rtl/friscv_div_ctrl.sv
// Sequences RISC-V M-extension DIV/DIVU/REM/REMU through an external divider, bypassing corner cases.
// Build option FRISCV_DIV_CACHE_EN adds a one-entry result cache keyed on {signed, rs1, rs2}.
module friscv_div_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            srst,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    output logic            div_pending,
    output logic            div_valid,
    input  logic            div_ready,
    output logic            div_signed,
    output logic [XLEN-1:0] div_divd,
    output logic [XLEN-1:0] div_divs,
    input  logic            div_o_valid,
    output logic            div_o_ready,
    input  logic [XLEN-1:0] div_quot,
    input  logic [XLEN-1:0] div_rem,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_val,
    output logic            wb_illegal
);

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t state;
    logic   op_rem;

    logic            illegal_c;
    logic            rem_c;
    logic            signed_c;
    logic            div_zero_c;
    logic            ovf_c;
    logic            bypass_c;
    logic            hit_c;
    logic            capture_c;
    logic [XLEN-1:0] bypass_val_c;
    logic [XLEN-1:0] cache_val_c;

    // Decode of the presented instruction and its architecturally defined corner-case results
    always_comb begin
        illegal_c    = ~funct3[2];
        rem_c        = funct3[1];
        signed_c     = ~funct3[0];
        div_zero_c   = (rs2_val == '0);
        ovf_c        = signed_c && (rs1_val == SMIN) && (rs2_val == ONES);
        bypass_c     = illegal_c || div_zero_c || ovf_c;
        bypass_val_c = '0;
        if (illegal_c) begin
            bypass_val_c = '0;
        end else if (div_zero_c) begin
            bypass_val_c = rem_c ? rs1_val : ONES;
        end else if (ovf_c) begin
            bypass_val_c = rem_c ? '0 : rs1_val;
        end
    end

    assign capture_c = (state == WAIT) && div_o_valid;

`ifdef FRISCV_DIV_CACHE_EN
    logic            cache_valid;
    logic            cache_signed;
    logic [XLEN-1:0] cache_rs1;
    logic [XLEN-1:0] cache_rs2;
    logic [XLEN-1:0] cache_quot;
    logic [XLEN-1:0] cache_rem;

    // Last divider result; the operands are still held on div_divd/div_divs at capture time
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cache_valid  <= 1'b0;
            cache_signed <= 1'b0;
            cache_rs1    <= '0;
            cache_rs2    <= '0;
            cache_quot   <= '0;
            cache_rem    <= '0;
        end else if (srst) begin
            cache_valid  <= 1'b0;
        end else if (capture_c) begin
            cache_valid  <= 1'b1;
            cache_signed <= div_signed;
            cache_rs1    <= div_divd;
            cache_rs2    <= div_divs;
            cache_quot   <= div_quot;
            cache_rem    <= div_rem;
        end
    end

    assign hit_c       = cache_valid && (cache_signed == signed_c) &&
                         (cache_rs1 == rs1_val) && (cache_rs2 == rs2_val);
    assign cache_val_c = rem_c ? cache_rem : cache_quot;
`else
    assign hit_c       = 1'b0;
    assign cache_val_c = '0;
`endif

    // Control FSM; every output is a register updated alongside the state
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            op_rem      <= 1'b0;
            i_ready     <= 1'b0;
            div_pending <= 1'b0;
            div_valid   <= 1'b0;
            div_signed  <= 1'b0;
            div_divd    <= '0;
            div_divs    <= '0;
            div_o_ready <= 1'b0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_val      <= '0;
            wb_illegal  <= 1'b0;
        end else if (srst) begin
            state       <= IDLE;
            op_rem      <= 1'b0;
            i_ready     <= 1'b0;
            div_pending <= 1'b0;
            div_valid   <= 1'b0;
            div_signed  <= 1'b0;
            div_divd    <= '0;
            div_divs    <= '0;
            div_o_ready <= 1'b0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_val      <= '0;
            wb_illegal  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    i_ready <= 1'b1;
                    if (i_valid && i_ready) begin
                        i_ready     <= 1'b0;
                        div_pending <= 1'b1;
                        op_rem      <= rem_c;
                        div_signed  <= signed_c;
                        div_divd    <= rs1_val;
                        div_divs    <= rs2_val;
                        wb_addr     <= rd_addr;
                        if (bypass_c) begin
                            state      <= WB;
                            wb_valid   <= 1'b1;
                            wb_val     <= bypass_val_c;
                            wb_illegal <= illegal_c;
                        end else if (hit_c) begin
                            state      <= WB;
                            wb_valid   <= 1'b1;
                            wb_val     <= cache_val_c;
                            wb_illegal <= 1'b0;
                        end else begin
                            state      <= ISSUE;
                            div_valid  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (div_ready) begin
                        state       <= WAIT;
                        div_valid   <= 1'b0;
                        div_o_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (capture_c) begin
                        state       <= WB;
                        div_o_ready <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_val      <= op_rem ? div_rem : div_quot;
                        wb_illegal  <= 1'b0;
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        state       <= IDLE;
                        wb_valid    <= 1'b0;
                        wb_illegal  <= 1'b0;
                        div_pending <= 1'b0;
                        i_ready     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_friscv_div_ctrl.sv
// Directed plus random bench for friscv_div_ctrl with a behavioural divider and a writeback scoreboard.
module tb_friscv_div_ctrl;

    localparam int unsigned XLEN = 32;

`ifdef FRISCV_DIV_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic            aclk = 1'b0;
    logic            areset;
    logic            srst;
    logic            i_valid;
    logic            i_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_addr;
    logic            div_pending;
    logic            div_valid;
    logic            div_ready;
    logic            div_signed;
    logic [XLEN-1:0] div_divd;
    logic [XLEN-1:0] div_divs;
    logic            div_o_valid;
    logic            div_o_ready;
    logic [XLEN-1:0] div_quot;
    logic [XLEN-1:0] div_rem;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_val;
    logic            wb_illegal;

    friscv_div_ctrl #(.XLEN(XLEN)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .srst        (srst),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .funct3      (funct3),
        .rs1_val     (rs1_val),
        .rs2_val     (rs2_val),
        .rd_addr     (rd_addr),
        .div_pending (div_pending),
        .div_valid   (div_valid),
        .div_ready   (div_ready),
        .div_signed  (div_signed),
        .div_divd    (div_divd),
        .div_divs    (div_divs),
        .div_o_valid (div_o_valid),
        .div_o_ready (div_o_ready),
        .div_quot    (div_quot),
        .div_rem     (div_rem),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_addr     (wb_addr),
        .wb_val      (wb_val),
        .wb_illegal  (wb_illegal)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [4:0]      addr;
        logic [XLEN-1:0] val;
        logic            ill;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference one-entry cache state (only consulted when CACHE is set)
    bit              c_valid = 1'b0;
    bit              c_signed;
    logic [XLEN-1:0] c_a;
    logic [XLEN-1:0] c_b;

    // Behavioural divider: fixed latency, resets with the controller
    logic mbusy;
    int   mlat;
    int   div_hs = 0;
    logic div_ready_en;

    assign div_ready = div_ready_en && !mbusy && !div_o_valid;

    always @(posedge aclk or posedge areset) begin
        if (areset || srst) begin
            mbusy       <= 1'b0;
            mlat        <= 0;
            div_o_valid <= 1'b0;
            div_quot    <= '0;
            div_rem     <= '0;
        end else begin
            if (div_valid && div_ready) begin
                mbusy  <= 1'b1;
                mlat   <= 2;
                div_hs <= div_hs + 1;
                if (div_divs == '0 || (div_signed && div_divd == 32'h8000_0000 && div_divs == 32'hFFFF_FFFF)) begin
                    div_quot <= 32'hDEAD_BEEF;
                    div_rem  <= 32'hDEAD_BEEF;
                end else if (div_signed) begin
                    div_quot <= 32'($signed(div_divd) / $signed(div_divs));
                    div_rem  <= 32'($signed(div_divd) % $signed(div_divs));
                end else begin
                    div_quot <= div_divd / div_divs;
                    div_rem  <= div_divd % div_divs;
                end
            end else if (mbusy) begin
                if (mlat == 0) begin
                    div_o_valid <= 1'b1;
                    mbusy       <= 1'b0;
                end else begin
                    mlat <= mlat - 1;
                end
            end
            if (div_o_valid && div_o_ready) div_o_valid <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_bypass(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return !f3[2] || (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_val(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 32'h0;
        if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : a;
        if (!f3[0]) return f3[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return f3[1] ? a % b : a / b;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // One full instruction: drive, check issue/bypass, optionally stall both sides, score writeback
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] ev, input logic ei,
                         input bit stall_div, input bit stall_wb, input string tag);
        bit   byp;
        int   hs0;
        int   n;
        exp_t e;
        byp = ref_bypass(f3, a, b) ||
              (CACHE && c_valid && c_signed == !f3[0] && c_a == a && c_b == b);
        sb_q.push_back('{addr: rd, val: ev, ill: ei});
        div_ready_en = !stall_div;
        wb_ready     = !stall_wb;
        funct3 = f3; rs1_val = a; rs2_val = b; rd_addr = rd; i_valid = 1'b1;
        n = 0;
        while (i_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk({tag, ".accept_timeout"}, 32'(n >= 50), 32'd0);
        hs0 = div_hs;
        tick();
        i_valid = 1'b0;
        rs1_val = $urandom; rs2_val = $urandom; funct3 = 3'($urandom); rd_addr = 5'($urandom);
        chk({tag, ".i_ready_busy"}, 32'(i_ready), 32'd0);
        chk({tag, ".pending"}, 32'(div_pending), 32'd1);
        chk({tag, ".bypass_wb_valid"}, 32'(wb_valid), 32'(byp));
        chk({tag, ".div_valid"}, 32'(div_valid), 32'(!byp));
        if (!byp) begin
            chk({tag, ".div_signed"}, 32'(div_signed), 32'(!f3[0]));
            chk({tag, ".div_divd"}, div_divd, a);
            chk({tag, ".div_divs"}, div_divs, b);
        end
        if (stall_div) begin
            for (int k = 0; k < 5; k++) begin
                tick();
                chk({tag, ".stall_div_valid"}, 32'(div_valid), 32'd1);
                chk({tag, ".stall_divd"}, div_divd, a);
                chk({tag, ".stall_divs"}, div_divs, b);
                chk({tag, ".stall_i_ready"}, 32'(i_ready), 32'd0);
            end
            div_ready_en = 1'b1;
        end
        n = 0;
        while (wb_valid !== 1'b1 && n < 50) begin tick(); n++; end
        chk({tag, ".wb_timeout"}, 32'(n >= 50), 32'd0);
        chk({tag, ".wb_div_valid_low"}, 32'(div_valid), 32'd0);
        chk({tag, ".wb_div_o_ready_low"}, 32'(div_o_ready), 32'd0);
        if (stall_wb) begin
            for (int k = 0; k < 5; k++) begin
                tick();
                chk({tag, ".stall_wb_valid"}, 32'(wb_valid), 32'd1);
                chk({tag, ".stall_wb_val"}, wb_val, ev);
                chk({tag, ".stall_wb_addr"}, 32'(wb_addr), 32'(rd));
                chk({tag, ".stall_wb_i_ready"}, 32'(i_ready), 32'd0);
            end
            wb_ready = 1'b1;
        end
        if (sb_q.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".wb_val"}, wb_val, e.val);
            chk({tag, ".wb_addr"}, 32'(wb_addr), 32'(e.addr));
            chk({tag, ".wb_illegal"}, 32'(wb_illegal), 32'(e.ill));
        end
        tick();
        chk({tag, ".wb_drop"}, 32'(wb_valid), 32'd0);
        chk({tag, ".i_ready_back"}, 32'(i_ready), 32'd1);
        chk({tag, ".pending_clear"}, 32'(div_pending), 32'd0);
        chk({tag, ".div_handshakes"}, 32'(div_hs - hs0), byp ? 32'd0 : 32'd1);
        if (!byp) begin
            c_valid = 1'b1; c_signed = !f3[0]; c_a = a; c_b = b;
        end
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        int          n;

        areset = 1'b1; srst = 1'b0; i_valid = 1'b0; funct3 = '0;
        rs1_val = '0; rs2_val = '0; rd_addr = '0; wb_ready = 1'b1; div_ready_en = 1'b1;
        repeat (3) tick();
        chk("reset.i_ready", 32'(i_ready), 32'd0);
        chk("reset.pending", 32'(div_pending), 32'd0);
        chk("reset.div_valid", 32'(div_valid), 32'd0);
        chk("reset.wb_valid", 32'(wb_valid), 32'd0);
        chk("reset.wb_val", wb_val, 32'd0);
        areset = 1'b0;
        tick();
        chk("reset.i_ready_rise", 32'(i_ready), 32'd1);

        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, "div_m7_2");
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "rem_m7_2");
        do_op(3'b101, 32'h0000_1234, 32'd0, 5'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "divu_by0");
        do_op(3'b111, 32'h0000_1234, 32'd0, 5'd8, 32'h0000_1234, 1'b0, 1'b0, 1'b0, "remu_by0");
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1'b0, 1'b0, 1'b0, "div_ovf");
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0, 1'b0, 1'b0, 1'b0, "rem_ovf");
        do_op(3'b000, 32'h0000_0055, 32'd3, 5'd11, 32'h0, 1'b1, 1'b0, 1'b1, "illegal_000");
        do_op(3'b101, 32'd1000, 32'd3, 5'd0, 32'd333, 1'b0, 1'b1, 1'b1, "divu_stall_rd0");
        do_op(3'b101, 32'd100, 32'd7, 5'd12, 32'd14, 1'b0, 1'b0, 1'b0, "divu_100_7");
        do_op(3'b111, 32'd100, 32'd7, 5'd13, 32'd2, 1'b0, 1'b0, 1'b0, "remu_100_7");

        // Asynchronous reset while the divider is working: instruction abandoned
        funct3 = 3'b100; rs1_val = 32'd100; rs2_val = 32'd3; rd_addr = 5'd14; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        n = 0;
        while (div_o_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("areset.wait_timeout", 32'(n >= 50), 32'd0);
        areset = 1'b1;
        #1;
        chk("areset.async_i_ready", 32'(i_ready), 32'd0);
        chk("areset.async_pending", 32'(div_pending), 32'd0);
        chk("areset.async_o_ready", 32'(div_o_ready), 32'd0);
        tick();
        tick();
        areset = 1'b0;
        c_valid = 1'b0;
        tick();
        chk("areset.i_ready_release", 32'(i_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("areset.no_wb", 32'(wb_valid), 32'd0);
            tick();
        end
        do_op(3'b100, 32'd100, 32'd3, 5'd14, 32'd33, 1'b0, 1'b0, 1'b0, "div_after_areset");

        // Synchronous reset while an issue is stalled
        div_ready_en = 1'b0;
        funct3 = 3'b101; rs1_val = 32'd55; rs2_val = 32'd5; rd_addr = 5'd15; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("srst.issue_div_valid", 32'(div_valid), 32'd1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        c_valid = 1'b0;
        chk("srst.div_valid", 32'(div_valid), 32'd0);
        chk("srst.i_ready", 32'(i_ready), 32'd0);
        chk("srst.pending", 32'(div_pending), 32'd0);
        tick();
        chk("srst.i_ready_release", 32'(i_ready), 32'd1);
        div_ready_en = 1'b1;

        for (int i = 0; i < 16; i++) begin
            rf3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : {1'b1, 2'($urandom)};
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : 32'($urandom);
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            do_op(rf3, ra, rb, 5'($urandom), ref_val(rf3, ra, rb), !rf3[2], 1'b0, 1'b0, "random");
        end

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
